// File: rtl/gpu_bus_pkg.sv
// rtl/gpu_bus_pkg.sv - register offsets, VRAM region map and region select type
package gpu_bus_pkg;

    // CPU register window offsets
    localparam logic [2:0] REG_ADDR_LO = 3'd4;
    localparam logic [2:0] REG_ADDR_HI = 3'd5;
    localparam logic [2:0] REG_DATA    = 3'd6;

    // VRAM pointer map
    localparam logic [15:0] TILE_BASE  = 16'h0000;
    localparam logic [15:0] ATTR_BASE  = 16'h0800;
    localparam logic [15:0] COLOR_BASE = 16'h1800;
    localparam logic [15:0] COLOR_END  = 16'h180F;

    typedef enum logic [1:0] {
        REGION_NONE  = 2'd0,
        REGION_TILE  = 2'd1,
        REGION_ATTR  = 2'd2,
        REGION_COLOR = 2'd3
    } region_e;

endpackage

// File: rtl/gpu_bus_interface_if.sv
// rtl/gpu_bus_interface_if.sv - CPU bus inputs and VRAM write-port outputs
interface gpu_bus_interface_if #(
    parameter int TILE_AW  = 11,
    parameter int ATTR_AW  = 12,
    parameter int COLOR_AW = 4
);
    logic [7:0]          data;
    logic [2:0]          addr;
    logic                rw;
    logic                cs;
    logic                cpu_clk;

    logic                tile_memory_write_enable;
    logic [TILE_AW-1:0]  tile_memory_write_addr;
    logic [7:0]          tile_memory_write_data;
    logic                attribute_memory_write_enable;
    logic [ATTR_AW-1:0]  attribute_memory_write_addr;
    logic [7:0]          attribute_memory_write_data;
    logic                color_memory_write_enable;
    logic [COLOR_AW-1:0] color_memory_write_addr;
    logic [7:0]          color_memory_write_data;

    modport master (
        output data, addr, rw, cs, cpu_clk,
        input  tile_memory_write_enable, tile_memory_write_addr, tile_memory_write_data,
        input  attribute_memory_write_enable, attribute_memory_write_addr, attribute_memory_write_data,
        input  color_memory_write_enable, color_memory_write_addr, color_memory_write_data
    );

    modport slave (
        input  data, addr, rw, cs, cpu_clk,
        output tile_memory_write_enable, tile_memory_write_addr, tile_memory_write_data,
        output attribute_memory_write_enable, attribute_memory_write_addr, attribute_memory_write_data,
        output color_memory_write_enable, color_memory_write_addr, color_memory_write_data
    );
endinterface

// File: rtl/cpu_strobe_detect.sv
// rtl/cpu_strobe_detect.sv - one-clk pulse on each rising edge of the CPU bus clock
module cpu_strobe_detect (
    input  logic clk,
    input  logic reset,
    input  logic cpu_clk_i,
    output logic strobe_o
);
    logic cpu_clk_q;

    // Remember last sampled cpu_clk level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_clk_q <= 1'b0;
        end else begin
            cpu_clk_q <= cpu_clk_i;
        end
    end

    // High for the first clk after cpu_clk rises; the CPU holds it high at least one clk
    assign strobe_o = cpu_clk_i & ~cpu_clk_q;

endmodule

// File: rtl/gpu_bus_interface.sv
// rtl/gpu_bus_interface.sv - CPU register port to tile/attr/color VRAM writes; AUTO_INCREMENT_EN enables pointer post-increment
import gpu_bus_pkg::*;

module gpu_bus_interface #(
    parameter int TILE_AW  = 11,
    parameter int ATTR_AW  = 12,
    parameter int COLOR_AW = 4
) (
    input  logic                clk,
    input  logic                reset,
    gpu_bus_interface_if.slave  bus
);
    logic                strobe;
    logic                accept;
    region_e             region;

    logic [15:0]         pointer_q,   pointer_d;
    logic                tile_we_q,   tile_we_d;
    logic [TILE_AW-1:0]  tile_addr_q, tile_addr_d;
    logic [7:0]          tile_data_q, tile_data_d;
    logic                attr_we_q,   attr_we_d;
    logic [ATTR_AW-1:0]  attr_addr_q, attr_addr_d;
    logic [7:0]          attr_data_q, attr_data_d;
    logic                color_we_q,  color_we_d;
    logic [COLOR_AW-1:0] color_addr_q, color_addr_d;
    logic [7:0]          color_data_q, color_data_d;

    cpu_strobe_detect u_strobe (
        .clk       (clk),
        .reset     (reset),
        .cpu_clk_i (bus.cpu_clk),
        .strobe_o  (strobe)
    );

    assign accept = strobe & ~bus.cs & ~bus.rw;

    // Map the current pointer onto one VRAM region
    always_comb begin
        region = REGION_NONE;
        if (pointer_q < ATTR_BASE) begin
            region = REGION_TILE;
        end else if (pointer_q < COLOR_BASE) begin
            region = REGION_ATTR;
        end else if (pointer_q <= COLOR_END) begin
            region = REGION_COLOR;
        end
    end

    // Next state: any accepted access clears the write port, a data write re-arms one enable
    always_comb begin
        pointer_d    = pointer_q;
        tile_we_d    = tile_we_q;
        tile_addr_d  = tile_addr_q;
        tile_data_d  = tile_data_q;
        attr_we_d    = attr_we_q;
        attr_addr_d  = attr_addr_q;
        attr_data_d  = attr_data_q;
        color_we_d   = color_we_q;
        color_addr_d = color_addr_q;
        color_data_d = color_data_q;
        if (accept) begin
            tile_we_d    = 1'b0;
            tile_addr_d  = '0;
            tile_data_d  = '0;
            attr_we_d    = 1'b0;
            attr_addr_d  = '0;
            attr_data_d  = '0;
            color_we_d   = 1'b0;
            color_addr_d = '0;
            color_data_d = '0;
            case (bus.addr)
                REG_ADDR_LO: pointer_d[7:0]  = bus.data;
                REG_ADDR_HI: pointer_d[15:8] = bus.data;
                REG_DATA: begin
                    case (region)
                        REGION_TILE: begin
                            tile_we_d   = 1'b1;
                            tile_addr_d = TILE_AW'(pointer_q - TILE_BASE);
                            tile_data_d = bus.data;
                        end
                        REGION_ATTR: begin
                            attr_we_d   = 1'b1;
                            attr_addr_d = ATTR_AW'(pointer_q - ATTR_BASE);
                            attr_data_d = bus.data;
                        end
                        REGION_COLOR: begin
                            color_we_d   = 1'b1;
                            color_addr_d = COLOR_AW'(pointer_q - COLOR_BASE);
                            color_data_d = bus.data;
                        end
                        default: ;
                    endcase
`ifdef AUTO_INCREMENT_EN
                    // Current write already used the old pointer; 16-bit wrap is intended
                    pointer_d = pointer_q + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    // State registers; reset drops the enables immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer_q    <= '0;
            tile_we_q    <= 1'b0;
            tile_addr_q  <= '0;
            tile_data_q  <= '0;
            attr_we_q    <= 1'b0;
            attr_addr_q  <= '0;
            attr_data_q  <= '0;
            color_we_q   <= 1'b0;
            color_addr_q <= '0;
            color_data_q <= '0;
        end else begin
            pointer_q    <= pointer_d;
            tile_we_q    <= tile_we_d;
            tile_addr_q  <= tile_addr_d;
            tile_data_q  <= tile_data_d;
            attr_we_q    <= attr_we_d;
            attr_addr_q  <= attr_addr_d;
            attr_data_q  <= attr_data_d;
            color_we_q   <= color_we_d;
            color_addr_q <= color_addr_d;
            color_data_q <= color_data_d;
        end
    end

    assign bus.tile_memory_write_enable      = tile_we_q;
    assign bus.tile_memory_write_addr        = tile_addr_q;
    assign bus.tile_memory_write_data        = tile_data_q;
    assign bus.attribute_memory_write_enable = attr_we_q;
    assign bus.attribute_memory_write_addr   = attr_addr_q;
    assign bus.attribute_memory_write_data   = attr_data_q;
    assign bus.color_memory_write_enable     = color_we_q;
    assign bus.color_memory_write_addr       = color_addr_q;
    assign bus.color_memory_write_data       = color_data_q;

endmodule

// File: tb/tb_gpu_bus_interface.sv
// tb/tb_gpu_bus_interface.sv - scoreboard bench for gpu_bus_interface with three VRAM models
module tb_gpu_bus_interface;

    typedef struct packed {
        logic        t_we;
        logic [10:0] t_a;
        logic [7:0]  t_d;
        logic        a_we;
        logic [11:0] a_a;
        logic [7:0]  a_d;
        logic        c_we;
        logic [3:0]  c_a;
        logic [7:0]  c_d;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    logic write_clk;

    gpu_bus_interface_if #(.TILE_AW(11), .ATTR_AW(12), .COLOR_AW(4)) bus_if ();

    gpu_bus_interface #(.TILE_AW(11), .ATTR_AW(12), .COLOR_AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    assign write_clk = ~bus_if.cpu_clk;

    logic [7:0] tile_ram  [0:2047];
    logic [7:0] attr_ram  [0:4095];
    logic [7:0] color_ram [0:15];
    logic [7:0] sh_tile   [0:2047];
    logic [7:0] sh_attr   [0:4095];
    logic [7:0] sh_color  [0:15];

    always @(posedge write_clk) begin
        if (bus_if.tile_memory_write_enable)
            tile_ram[bus_if.tile_memory_write_addr] <= bus_if.tile_memory_write_data;
        if (bus_if.attribute_memory_write_enable)
            attr_ram[bus_if.attribute_memory_write_addr] <= bus_if.attribute_memory_write_data;
        if (bus_if.color_memory_write_enable)
            color_ram[bus_if.color_memory_write_addr] <= bus_if.color_memory_write_data;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ptr_m;
    out_t        exp_out;
    out_t        exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] ra, input logic [7:0] d, input logic rw, input logic cs);
        logic [15:0] off;
        if (!cs && !rw) begin
            exp_out = '0;
            case (ra)
                3'd4: ptr_m[7:0]  = d;
                3'd5: ptr_m[15:8] = d;
                3'd6: begin
                    if (ptr_m <= 16'h07FF) begin
                        exp_out.t_we = 1'b1;
                        exp_out.t_a  = ptr_m[10:0];
                        exp_out.t_d  = d;
                        sh_tile[ptr_m[10:0]] = d;
                    end else if (ptr_m <= 16'h17FF) begin
                        off = ptr_m - 16'h0800;
                        exp_out.a_we = 1'b1;
                        exp_out.a_a  = off[11:0];
                        exp_out.a_d  = d;
                        sh_attr[off[11:0]] = d;
                    end else if (ptr_m <= 16'h180F) begin
                        exp_out.c_we = 1'b1;
                        exp_out.c_a  = ptr_m[3:0];
                        exp_out.c_d  = d;
                        sh_color[ptr_m[3:0]] = d;
                    end
`ifdef AUTO_INCREMENT_EN
                    ptr_m = ptr_m + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_outputs(input string tag);
        out_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".t_we"}, 32'(bus_if.tile_memory_write_enable),      32'(e.t_we));
            check({tag, ".t_a"},  32'(bus_if.tile_memory_write_addr),        32'(e.t_a));
            check({tag, ".t_d"},  32'(bus_if.tile_memory_write_data),        32'(e.t_d));
            check({tag, ".a_we"}, 32'(bus_if.attribute_memory_write_enable), 32'(e.a_we));
            check({tag, ".a_a"},  32'(bus_if.attribute_memory_write_addr),   32'(e.a_a));
            check({tag, ".a_d"},  32'(bus_if.attribute_memory_write_data),   32'(e.a_d));
            check({tag, ".c_we"}, 32'(bus_if.color_memory_write_enable),     32'(e.c_we));
            check({tag, ".c_a"},  32'(bus_if.color_memory_write_addr),       32'(e.c_a));
            check({tag, ".c_d"},  32'(bus_if.color_memory_write_data),       32'(e.c_d));
        end
    endtask

    task automatic ram_check(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 2048; i++) if (tile_ram[i] !== sh_tile[i]) diff++;
        for (int i = 0; i < 4096; i++) if (attr_ram[i] !== sh_attr[i]) diff++;
        for (int i = 0; i < 16; i++)   if (color_ram[i] !== sh_color[i]) diff++;
        check({tag, ".ram_diffs"}, 32'(diff), 32'd0);
    endtask

    task automatic cpu_access(input logic [2:0] ra, input logic [7:0] d, input logic rw,
                              input logic cs, input string tag);
        @(negedge clk);
        bus_if.addr    = ra;
        bus_if.data    = d;
        bus_if.rw      = rw;
        bus_if.cs      = cs;
        bus_if.cpu_clk = 1'b1;
        model(ra, d, rw, cs);
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        compare_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        bus_if.cpu_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ram_check(tag);
    endtask

    task automatic set_ptr(input logic [15:0] p, input logic rw, input logic cs, input string tag);
        cpu_access(3'd4, p[7:0],  rw, cs, tag);
        cpu_access(3'd5, p[15:8], rw, cs, tag);
    endtask

    task automatic vram_write(input logic [15:0] p, input logic [7:0] d, input string tag);
        set_ptr(p, 1'b0, 1'b0, tag);
        cpu_access(3'd6, d, 1'b0, 1'b0, tag);
    endtask

    logic [15:0] bounds [0:6];

    initial begin
        for (int i = 0; i < 2048; i++) begin tile_ram[i] = 8'h00; sh_tile[i] = 8'h00; end
        for (int i = 0; i < 4096; i++) begin attr_ram[i] = 8'h00; sh_attr[i] = 8'h00; end
        for (int i = 0; i < 16; i++)   begin color_ram[i] = 8'h00; sh_color[i] = 8'h00; end
        ptr_m          = 16'h0000;
        exp_out        = '0;
        reset          = 1'b1;
        bus_if.cpu_clk = 1'b0;
        bus_if.cs      = 1'b1;
        bus_if.rw      = 1'b1;
        bus_if.addr    = 3'd0;
        bus_if.data    = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back('0);
        compare_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Directed region writes
        cpu_access(3'd4, 8'h00, 1'b0, 1'b0, "tile_lo");
        cpu_access(3'd5, 8'h01, 1'b0, 1'b0, "tile_hi");
        cpu_access(3'd6, 8'hAA, 1'b0, 1'b0, "tile_wr");
        check("tile_0x100", 32'(tile_ram[11'h100]), 32'h0000_00AA);
        vram_write(16'h0900, 8'h0E, "attr_wr");
        check("attr_0x100", 32'(attr_ram[12'h100]), 32'h0000_000E);
        vram_write(16'h1802, 8'hBE, "color_wr");
        check("color_0x2", 32'(color_ram[4'h2]), 32'h0000_00BE);
        vram_write(16'h2000, 8'h55, "drop_wr");

        // Region boundaries
        bounds[0] = 16'h07FF; bounds[1] = 16'h0800; bounds[2] = 16'h17FF; bounds[3] = 16'h1800;
        bounds[4] = 16'h180F; bounds[5] = 16'h1810; bounds[6] = 16'hFFFF;
        for (int i = 0; i < 7; i++) vram_write(bounds[i], 8'h30 + 8'(i), "bound");

        // Reads and deselected accesses leave pointer and RAMs alone
        vram_write(16'h0123, 8'h42, "pre_ign");
        set_ptr(16'h1805, 1'b1, 1'b0, "rd_ptr");
        cpu_access(3'd6, 8'h99, 1'b1, 1'b0, "rd_data");
        set_ptr(16'h0900, 1'b0, 1'b1, "cs_ptr");
        cpu_access(3'd6, 8'h98, 1'b0, 1'b1, "cs_data");
        cpu_access(3'd6, 8'h43, 1'b0, 1'b0, "post_ign");

        // Ignored register offsets still clear the write port
        vram_write(16'h0010, 8'h61, "pre_clr");
        cpu_access(3'd0, 8'hFF, 1'b0, 1'b0, "reg0");
        cpu_access(3'd6, 8'h62, 1'b0, 1'b0, "re_arm");
        cpu_access(3'd7, 8'hFF, 1'b0, 1'b0, "reg7");

        // Back-to-back data writes and the tile/attr boundary with increment
        set_ptr(16'h07FF, 1'b0, 1'b0, "inc_ptr");
        cpu_access(3'd6, 8'h11, 1'b0, 1'b0, "inc_wr1");
        cpu_access(3'd6, 8'h22, 1'b0, 1'b0, "inc_wr2");
`ifdef AUTO_INCREMENT_EN
        check("inc_tile", 32'(tile_ram[11'h7FF]), 32'h0000_0011);
        check("inc_attr", 32'(attr_ram[12'h000]), 32'h0000_0022);
        vram_write(16'hFFFF, 8'h01, "wrap_wr");
        cpu_access(3'd6, 8'h02, 1'b0, 1'b0, "wrap_nxt");
        check("wrap_tile0", 32'(tile_ram[11'h000]), 32'h0000_0002);
`else
        check("inc_tile", 32'(tile_ram[11'h7FF]), 32'h0000_0022);
`endif

        // Random accesses
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ra;
            logic [7:0] d;
            ra = 3'($urandom_range(3, 7));
            d  = 8'($urandom_range(0, 255));
            if (ra == 3'd5) d = 8'($urandom_range(0, 8'h19));
            cpu_access(ra, d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), "rand");
        end

        // Reset while the write port is asserted
        vram_write(16'h0100, 8'h5A, "pre_rst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_t_we", 32'(bus_if.tile_memory_write_enable),      32'd0);
        check("rst_a_we", 32'(bus_if.attribute_memory_write_enable), 32'd0);
        check("rst_c_we", 32'(bus_if.color_memory_write_enable),     32'd0);
        check("rst_t_a",  32'(bus_if.tile_memory_write_addr),        32'd0);
        ptr_m   = 16'h0000;
        exp_out = '0;
        @(negedge clk);
        reset = 1'b0;
        cpu_access(3'd6, 8'h77, 1'b0, 1'b0, "post_rst");
        check("post_rst_tile0", 32'(tile_ram[11'h000]), 32'h0000_0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
